// File: rtl/codec_i2c_arbiter.sv
// Round-robin arbiter sharing one codec I2C write master between N_REQ sources.
// Prepends DEV_ADDR to the granted word and runs the go/ack/ready handshake with a timeout.
module codec_i2c_arbiter #(
  parameter int unsigned N_REQ       = 2,
  parameter logic [7:0]  DEV_ADDR    = 8'h34,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic                 busy,
  output logic [23:0]          i2c_data,
  output logic                 i2c_go,
  input  logic                 i2c_ack,
  input  logic                 i2c_ready,
  input  logic                 i2c_nack
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW:0]   N_REQ_W  = (PW+1)'(N_REQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  // WAIT_GAP is the cycle after ack where i2c_ready is still stale from the master.
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_GAP, WAIT_DONE} state_t;

  state_t            state, state_d;
  logic [PW-1:0]     rr_ptr, rr_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [N_REQ-1:0]  grant_d, done_d;
  logic              err_d, busy_d, go_d;
  logic [23:0]       data_d;
  logic              pick_valid;
  logic [PW-1:0]     pick_idx;
  logic              timeout;
  logic              finish, fin_err;
  logic [15:0]       words [N_REQ];

  for (genvar gi = 0; gi < int'(N_REQ); gi++) begin : g_word
    assign words[gi] = req_data[16*gi +: 16];
  end

  assign timeout = (cnt == CNT_LAST);

  // Search from rr_ptr+1 upward (mod N_REQ); descending loop leaves the nearest hit.
  always_comb begin : rr_pick
    logic [PW:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = int'(N_REQ); i >= 1; i--) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(i);
      if (cand >= N_REQ_W) cand = cand - N_REQ_W;
      if (req[cand[PW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state and next registered outputs; timeout outranks ack/ready.
  always_comb begin : fsm_next
    state_d = state;
    grant_d = grant;
    done_d  = '0;
    err_d   = 1'b0;
    busy_d  = busy;
    go_d    = i2c_go;
    data_d  = i2c_data;
    rr_d    = rr_ptr;
    cnt_d   = cnt;
    finish  = 1'b0;
    fin_err = 1'b0;
    if (state != IDLE) cnt_d = cnt + CW'(1);
    case (state)
      IDLE: begin
        // Issue is held off during the done cycle so the old owner's req can drop.
        if (pick_valid && i2c_ready && (done == '0)) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          busy_d            = 1'b1;
          go_d              = 1'b1;
          data_d            = {DEV_ADDR, words[pick_idx]};
          rr_d              = pick_idx;
          cnt_d             = '0;
          state_d           = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (timeout) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else if (i2c_ack) begin
          go_d    = 1'b0;
          state_d = WAIT_GAP;
        end
      end
      WAIT_GAP: begin
        if (timeout) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (timeout) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else if (i2c_ready) begin
          finish  = 1'b1;
          fin_err = i2c_nack;
        end
      end
      default: state_d = IDLE;
    endcase
    if (finish) begin
      state_d = IDLE;
      done_d  = grant;
      err_d   = fin_err;
      grant_d = '0;
      busy_d  = 1'b0;
      go_d    = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin : out_reg
    if (!rst_n) begin
      grant    <= '0;
      done     <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      i2c_go   <= 1'b0;
      i2c_data <= '0;
      rr_ptr   <= PW'(N_REQ - 1);
      cnt      <= '0;
    end else begin
      grant    <= grant_d;
      done     <= done_d;
      err      <= err_d;
      busy     <= busy_d;
      i2c_go   <= go_d;
      i2c_data <= data_d;
      rr_ptr   <= rr_d;
      cnt      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_codec_i2c_arbiter.sv
// Self-checking bench for codec_i2c_arbiter: directed handshake scenarios plus
// randomized transactions against a round-robin reference model.
module tb_codec_i2c_arbiter;

  localparam int N = 2;
  localparam int T = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [31:0]   req_data;
  logic [N-1:0]  grant, done;
  logic          err, busy;
  logic [23:0]   i2c_data;
  logic          i2c_go;
  logic          i2c_ack, i2c_ready, i2c_nack;
  logic [15:0]   w [N];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rr_last = N - 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign req_data = {w[1], w[0]};

  codec_i2c_arbiter #(.N_REQ(N), .DEV_ADDR(8'h34), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .err(err), .busy(busy),
    .i2c_data(i2c_data), .i2c_go(i2c_go),
    .i2c_ack(i2c_ack), .i2c_ready(i2c_ready), .i2c_nack(i2c_nack)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_last = N - 1;
  endtask

  // Behaves as the I2C master for one transaction and records what the DUT did.
  task automatic master_txn(input int ack_lat, input int ready_lat, input bit nack,
                            output int go_cyc, output logic [N-1:0] g, output logic [23:0] d,
                            output bit go_held, output bit go_dropped, output int ack_cyc,
                            output int done_cyc, output logic [N-1:0] dn, output logic e,
                            output logic [N-1:0] g_after, output logic b_after, output bit lost);
    bit found = 0;
    lost = 0; go_cyc = -1; ack_cyc = -1; done_cyc = -1; g = 'x; d = 'x;
    go_held = 0; go_dropped = 0; dn = 'x; e = 'x; g_after = 'x; b_after = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i2c_go) begin found = 1; break; end
    end
    if (!found) begin lost = 1; return; end
    go_cyc = cyc; g = grant; d = i2c_data; go_held = 1;
    repeat (ack_lat) begin @(negedge clk); if (!i2c_go) go_held = 0; end
    ack_cyc = cyc; i2c_ack = 1'b1; i2c_ready = 1'b0;
    @(negedge clk);
    i2c_ack = 1'b0; go_dropped = !i2c_go;
    repeat (ready_lat) @(negedge clk);
    i2c_ready = 1'b1; i2c_nack = nack;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done != '0) begin found = 1; break; end
    end
    i2c_nack = 1'b0;
    if (!found) begin lost = 1; return; end
    done_cyc = cyc; dn = done; e = err; g_after = grant; b_after = busy;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got=%b exp=00", done); end
    checks++; if ({err, busy, i2c_go} !== 3'b000) begin errors++; $display("FAIL reset_flags err/busy/go got=%b exp=000", {err, busy, i2c_go}); end
    checks++; if (i2c_data !== 24'h0) begin errors++; $display("FAIL reset_data got=%h exp=000000", i2c_data); end
  endtask

  task automatic test_single();
    int gc, ac, dc, c0; logic [N-1:0] g, dn, ga; logic [23:0] d; logic e, ba; bit gh, gd, lost;
    w[0] = 16'h0C00; w[1] = 16'h0000; i2c_ready = 1'b1; req = 2'b01; c0 = cyc;
    master_txn(2, 6, 1'b0, gc, g, d, gh, gd, ac, dc, dn, e, ga, ba, lost);
    req = 2'b00;
    checks++; if (lost) begin errors++; $display("FAIL single_lost got=no_event exp=go_and_done"); end
    checks++; if (gc - c0 !== 1) begin errors++; $display("FAIL single_go_latency got=%0d exp=1", gc - c0); end
    checks++; if (d !== 24'h340C00) begin errors++; $display("FAIL single_data got=%h exp=340c00", d); end
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", g); end
    checks++; if (!gh || !gd) begin errors++; $display("FAIL single_go_shape held=%0d dropped=%0d exp=1,1", gh, gd); end
    checks++; if (dc - c0 !== 11) begin errors++; $display("FAIL single_done_latency got=%0d exp=11", dc - c0); end
    checks++; if ({dn, e} !== 3'b010) begin errors++; $display("FAIL single_done_err got=%b exp=010", {dn, e}); end
    checks++; if ({ga, ba} !== 3'b000) begin errors++; $display("FAIL single_release got=%b exp=000", {ga, ba}); end
    checks++; if (i2c_data !== 24'h340C00) begin errors++; $display("FAIL single_data_hold got=%h exp=340c00", i2c_data); end
    rr_last = 0;
    idle(3);
  endtask

  task automatic test_fairness();
    int gc, ac, dc, prev_dc; logic [N-1:0] g, dn, ga; logic [23:0] d; logic e, ba; bit gh, gd, lost;
    apply_reset();
    w[0] = 16'h1111; w[1] = 16'h2222; req = 2'b11; i2c_ready = 1'b1; prev_dc = 0;
    for (int k = 0; k < 4; k++) begin
      master_txn(0, 0, 1'b0, gc, g, d, gh, gd, ac, dc, dn, e, ga, ba, lost);
      checks++; if (g !== N'(1 << (k % 2))) begin errors++; $display("FAIL fair_grant[%0d] got=%b exp=%b", k, g, N'(1 << (k % 2))); end
      checks++; if (dn !== g || e !== 1'b0) begin errors++; $display("FAIL fair_done[%0d] got=%b/%b exp=%b/0", k, dn, e, g); end
      checks++; if (d !== {8'h34, w[k % 2]}) begin errors++; $display("FAIL fair_data[%0d] got=%h exp=%h", k, d, {8'h34, w[k % 2]}); end
      if (k > 0) begin
        checks++; if (gc - prev_dc !== 2) begin errors++; $display("FAIL fair_gap[%0d] got=%0d exp=2", k, gc - prev_dc); end
      end
      prev_dc = dc;
    end
    req = 2'b00; rr_last = 1;
    idle(3);
  endtask

  task automatic test_nack();
    int gc, ac, dc, dc0; logic [N-1:0] g, dn, ga; logic [23:0] d; logic e, ba; bit gh, gd, lost;
    w[1] = 16'($urandom); req = 2'b10; i2c_ready = 1'b1;
    master_txn(1, 2, 1'b1, gc, g, d, gh, gd, ac, dc, dn, e, ga, ba, lost);
    checks++; if ({dn, e} !== 3'b101) begin errors++; $display("FAIL nack_done_err got=%b exp=101", {dn, e}); end
    checks++; if (dc - ac !== 4) begin errors++; $display("FAIL nack_done_latency got=%0d exp=4", dc - ac); end
    dc0 = dc;
    master_txn(0, 1, 1'b0, gc, g, d, gh, gd, ac, dc, dn, e, ga, ba, lost);
    checks++; if ({dn, e} !== 3'b100) begin errors++; $display("FAIL nack_recover got=%b exp=100", {dn, e}); end
    checks++; if (gc - dc0 !== 2) begin errors++; $display("FAIL nack_gap got=%0d exp=2", gc - dc0); end
    req = 2'b00; rr_last = 1;
    idle(3);
  endtask

  task automatic test_timeout();
    int gc, go_cnt, ac, dc; bit found, lost, gh, gd; logic [N-1:0] g, dn, ga; logic [23:0] d; logic e, ba;
    w[0] = 16'($urandom); req = 2'b01; i2c_ready = 1'b1; found = 0; go_cnt = 0; gc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i2c_go) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL timeout_go got=none exp=go"); end
    gc = cyc; go_cnt = 1;
    // Master never acks; a late ack lands in the cycle the timeout fires.
    for (int k = 1; k < T; k++) begin
      @(negedge clk);
      if (i2c_go) go_cnt++;
      if (k == T - 1) i2c_ack = 1'b1;
    end
    @(negedge clk);
    i2c_ack = 1'b0; req = 2'b00;
    checks++; if (go_cnt !== T) begin errors++; $display("FAIL timeout_go_cycles got=%0d exp=%0d", go_cnt, T); end
    checks++; if (cyc - gc !== T) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", cyc - gc, T); end
    checks++; if ({done, err} !== 3'b011) begin errors++; $display("FAIL timeout_done_err got=%b exp=011", {done, err}); end
    checks++; if ({i2c_go, busy, grant} !== 4'b0000) begin errors++; $display("FAIL timeout_release got=%b exp=0000", {i2c_go, busy, grant}); end
    @(negedge clk);
    checks++; if ({done, err, i2c_go} !== 4'b0000) begin errors++; $display("FAIL timeout_pulse got=%b exp=0000", {done, err, i2c_go}); end
    req = 2'b01;
    master_txn(0, 0, 1'b0, gc, g, d, gh, gd, ac, dc, dn, e, ga, ba, lost);
    checks++; if (lost || {dn, e} !== 3'b010) begin errors++; $display("FAIL timeout_recover got=%b exp=010", {dn, e}); end
    req = 2'b00; rr_last = 0;
    idle(3);
  endtask

  task automatic test_ready_low();
    int gc, ac, dc, c0; logic [N-1:0] g, dn, ga; logic [23:0] d; logic e, ba; bit gh, gd, lost, saw;
    i2c_ready = 1'b0; req = 2'b01; w[0] = 16'hA5A5; saw = 0;
    repeat (5) begin @(negedge clk); if (i2c_go || busy) saw = 1; end
    checks++; if (saw) begin errors++; $display("FAIL ready_low_issue got=go exp=no_go"); end
    i2c_ready = 1'b1; c0 = cyc;
    master_txn(1, 1, 1'b0, gc, g, d, gh, gd, ac, dc, dn, e, ga, ba, lost);
    checks++; if (gc - c0 !== 1) begin errors++; $display("FAIL ready_low_latency got=%0d exp=1", gc - c0); end
    checks++; if (d !== 24'h34A5A5 || dn !== 2'b01) begin errors++; $display("FAIL ready_low_txn got=%h/%b exp=34a5a5/01", d, dn); end
    req = 2'b00; rr_last = 0;
    idle(3);
  endtask

  task automatic test_reset_mid();
    int gc, ac, dc; logic [N-1:0] g, dn, ga; logic [23:0] d; logic e, ba; bit gh, gd, lost, found, saw_done;
    w[0] = 16'h0101; w[1] = 16'h0202; req = 2'b10; i2c_ready = 1'b1; found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i2c_go) begin found = 1; break; end
    end
    i2c_ack = 1'b1; i2c_ready = 1'b0;
    @(negedge clk); i2c_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; req = 2'b11;
    @(negedge clk);
    checks++; if (!found || {grant, i2c_go, busy, done} !== 6'b000000) begin errors++; $display("FAIL reset_mid got=%b exp=000000", {grant, i2c_go, busy, done}); end
    i2c_ready = 1'b1; saw_done = 0;
    @(negedge clk); if (done != '0) saw_done = 1;
    rst_n = 1'b1; rr_last = N - 1;
    master_txn(0, 0, 1'b0, gc, g, d, gh, gd, ac, dc, dn, e, ga, ba, lost);
    checks++; if (saw_done) begin errors++; $display("FAIL reset_mid_done got=pulse exp=none"); end
    checks++; if (g !== 2'b01 || d !== 24'h340101) begin errors++; $display("FAIL reset_mid_first got=%b/%h exp=01/340101", g, d); end
    req = 2'b00; rr_last = 0;
    idle(3);
  endtask

  task automatic test_random();
    int gc, ac, dc, ref_pt, al, rl, owner, exp_done, exp_lat;
    logic [N-1:0] g, dn, ga, mask; logic [23:0] d; logic e, ba; bit gh, gd, lost, nk;
    i2c_ready = 1'b1;
    ref_pt = cyc;
    for (int t = 0; t < 25; t++) begin
      mask = N'($urandom_range(1, 3));
      for (int j = 0; j < N; j++) w[j] = 16'($urandom);
      req = mask;
      owner = -1;
      for (int k = 1; k <= N; k++)
        if (owner < 0 && mask[(rr_last + k) % N]) owner = (rr_last + k) % N;
      al = int'($urandom_range(0, 3)); rl = int'($urandom_range(0, 4)); nk = 1'($urandom);
      exp_lat = (t == 0) ? 1 : 2;
      ref_pt = cyc;
      master_txn(al, rl, nk, gc, g, d, gh, gd, ac, dc, dn, e, ga, ba, lost);
      exp_done = ((ac + 1 + rl > ac + 2) ? ac + 1 + rl : ac + 2) + 1;
      checks++; if (lost) begin errors++; $display("FAIL rand[%0d]_lost got=no_event exp=go_and_done", t); end
      checks++; if (gc - ref_pt !== exp_lat) begin errors++; $display("FAIL rand[%0d]_go_latency got=%0d exp=%0d", t, gc - ref_pt, exp_lat); end
      checks++; if (g !== N'(1 << owner)) begin errors++; $display("FAIL rand[%0d]_grant got=%b exp=%b", t, g, N'(1 << owner)); end
      checks++; if (d !== {8'h34, w[owner]}) begin errors++; $display("FAIL rand[%0d]_data got=%h exp=%h", t, d, {8'h34, w[owner]}); end
      checks++; if (!gh || !gd) begin errors++; $display("FAIL rand[%0d]_go_shape held=%0d dropped=%0d exp=1,1", t, gh, gd); end
      checks++; if (dc !== exp_done) begin errors++; $display("FAIL rand[%0d]_done_cycle got=%0d exp=%0d", t, dc - ac, exp_done - ac); end
      checks++; if (dn !== N'(1 << owner) || e !== nk) begin errors++; $display("FAIL rand[%0d]_done_err got=%b/%b exp=%b/%b", t, dn, e, N'(1 << owner), nk); end
      checks++; if ({ga, ba} !== 3'b000) begin errors++; $display("FAIL rand[%0d]_release got=%b exp=000", t, {ga, ba}); end
      rr_last = owner;
    end
    req = 2'b00;
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; w[0] = '0; w[1] = '0;
    i2c_ack = 1'b0; i2c_ready = 1'b1; i2c_nack = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_nack();
    test_timeout();
    test_ready_low();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
